lookup_tcam: RTL
================

Name: lookup_tcam

Overview:
- Match stage directly downstream of key_extract_2.
- Takes the extracted key and per-key care mask, plus the PHV carried alongside.
- Matches the key against a small ternary table, priority-resolved, and emits hit plus action address with the PHV, 2 cycles later.
- Table entries are written in-band over the control AXI-Stream; control packets not addressed here pass through to c_m_axis.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, control stream data width.
- C_S_AXIS_TUSER_WIDTH, 128, control stream tuser width.
- STAGE_ID, 0, stage number matched in control header.
- PHV_LEN, 1124, PHV width (48*8+32*8+16*8+5*20+256).
- KEY_LEN, 197, key width (48*2+32*2+16*2+5).
- ENTRIES, 16, table depth.
- ACT_ADDR_WIDTH, 4, log2(ENTRIES).
- LKUP_ID, 2, module ID matched in control header.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- phv_in  in  PHV_LEN  PHV from key extractor.
- phv_valid_in  in  1  qualifies phv_in.
- key_in  in  KEY_LEN  extracted key.
- key_mask_in  in  KEY_LEN  1 = bit participates in match.
- key_valid_in  in  1  qualifies key_in; asserted with phv_valid_in.
- phv_out  out  PHV_LEN  delayed PHV.
- phv_valid_out  out  1  qualifies phv_out.
- action_addr_out  out  ACT_ADDR_WIDTH  index of winning entry; 0 on miss.
- hit_out  out  1  any entry matched; valid with phv_valid_out.
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  per params  control input.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  per params  control output.

Behaviour:
- Reset: all outputs 0, all entry valid bits 0, control FSM to IDLE. Reset asserted mid-packet aborts the write; no entry is modified.
- No backpressure on either path. Lookup accepts one key per cycle.
- Lookup pipeline, latency 2, throughput 1 per cycle:
  - Cycle 1 registers the per-entry match vector and PHV. Entry i matches when valid[i], and ((key_in ^ key[i]) & key_mask_in & mask[i]) == 0.
  - Cycle 2 registers the outputs. The lowest matching index wins.
- Miss: hit_out=0, action_addr_out=0, PHV still forwarded.
- key_mask_in all-zero: any valid entry matches.
- No valid entries: miss.
- Control header beat:
  - tdata[127:124]=STAGE_ID[3:0].
  - tdata[123:120]=LKUP_ID.
  - tdata[119:112]=entry index.
- Control FSM states:
  - IDLE: a header beat for this module goes to KEY. A header beat for another module goes to FWD.
  - KEY: the beat's tdata[KEY_LEN-1:0] is latched as the staged key; go to MASK. If tlast is set on this beat, drop it and go to IDLE.
  - MASK: the beat's tdata[KEY_LEN-1:0] is written as mask[idx], staged key as key[idx], and valid[idx] set to 1. Then go to FLUSH, or to IDLE if tlast.
  - FLUSH: consume beats until tlast, then go to IDLE.
  - FWD: pass beats through until tlast, then go to IDLE.
- Index >= ENTRIES: beats are consumed and no write occurs.
- Pass-through path: one-cycle registered copy of all five fields. c_m_axis_tvalid=0 for consumed packets and whenever idle.
- Write vs lookup in the same cycle: the write commits at the clock edge. A key presented in the commit cycle sees the old entry; a key one cycle later sees the new one.
- Rewriting a valid entry overwrites key and mask; the entry stays valid.

Decomposition:
- Shared package holds: PHV_LEN, KEY_LEN, header field bit positions, module ID constants (KEY_EX_ID=1, LKUP_ID=2), and the control FSM state encoding.
- Sub-module: lookup_prio_enc, a parameterised ENTRIES-wide lowest-index priority encoder producing {hit, index}.

Test Plan:
- Reset, then entry 3 written with key=K (197'h1 shifted 5), mask all-ones; key K with mask all-ones presented -> 2 cycles later hit_out=1, action_addr_out=3, phv_out equals input PHV.
- Entries 2 and 5 both written to match K -> action_addr_out=2. Entry 2 then overwritten with a non-matching key -> next lookup gives 5.
- Key differing from entry 3 in bit 0, with key_mask_in bit 0 = 0 -> hit. Same key with mask bit 0 = 1 -> miss: hit_out=0, action_addr_out=0.
- Control packet with module ID 1 (key extractor) -> reproduced on c_m_axis 1 cycle later, beat-for-beat. Table is unchanged.
- Lookup in the MASK-write cycle for entry 7 -> miss. Identical lookup on the next cycle -> hit, addr 7.
- rst_n pulsed low between the KEY and MASK beats -> entry stays invalid, and a following well-formed packet writes correctly. Back-to-back keys on 10 consecutive cycles -> 10 consecutive phv_valid_out cycles, in order.

Source files
------------

// File: rtl/lookup_tcam_pkg.sv
// Shared constants for the lookup_tcam match stage: data widths, control-header
// field positions, module IDs and the control FSM state encoding.
package lookup_tcam_pkg;

    localparam int PHV_LEN   = 1124;
    localparam int KEY_LEN   = 197;
    localparam int KEY_EX_ID = 1;
    localparam int LKUP_ID   = 2;

    localparam int HDR_STAGE_HI = 127;
    localparam int HDR_STAGE_LO = 124;
    localparam int HDR_MOD_HI   = 123;
    localparam int HDR_MOD_LO   = 120;
    localparam int HDR_IDX_HI   = 119;
    localparam int HDR_IDX_LO   = 112;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_MASK  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FWD   = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/lookup_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is requested.
module lookup_prio_enc
    import lookup_tcam_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic         hit,
    output logic [W-1:0] idx
);

    always_comb begin
        hit = |req;
        idx = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/lookup_tcam.sv
// Ternary match stage: 2-cycle priority-resolved lookup of an extracted key, with
// table entries written in-band over the control stream and foreign packets forwarded.
module lookup_tcam
    import lookup_tcam_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int PHV_LEN              = lookup_tcam_pkg::PHV_LEN,
    parameter int KEY_LEN              = lookup_tcam_pkg::KEY_LEN,
    parameter int ENTRIES              = 16,
    parameter int ACT_ADDR_WIDTH       = 4,
    parameter int LKUP_ID              = lookup_tcam_pkg::LKUP_ID
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PHV_LEN-1:0]                   phv_in,
    input  logic                                 phv_valid_in,
    input  logic [KEY_LEN-1:0]                   key_in,
    input  logic [KEY_LEN-1:0]                   key_mask_in,
    input  logic                                 key_valid_in,
    output logic [PHV_LEN-1:0]                   phv_out,
    output logic                                 phv_valid_out,
    output logic [ACT_ADDR_WIDTH-1:0]            action_addr_out,
    output logic                                 hit_out,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    ctrl_state_e         state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic [KEY_LEN-1:0]  stage_key_q, stage_key_d;
    logic [KEY_LEN-1:0]  tbl_key_q [ENTRIES];
    logic [KEY_LEN-1:0]  tbl_key_d [ENTRIES];
    logic [KEY_LEN-1:0]  tbl_mask_q [ENTRIES];
    logic [KEY_LEN-1:0]  tbl_mask_d [ENTRIES];
    logic [ENTRIES-1:0]  tbl_valid_q, tbl_valid_d;

    logic [ENTRIES-1:0]  match_q, match_d;
    logic [PHV_LEN-1:0]  phv_s1_q, phv_s1_d;
    logic                vld_s1_q, vld_s1_d;

    logic [PHV_LEN-1:0]        phv_out_q, phv_out_d;
    logic                      phv_valid_out_q, phv_valid_out_d;
    logic [ACT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      hit_q, hit_d;

    logic [DW-1:0] cm_tdata_q, cm_tdata_d;
    logic [UW-1:0] cm_tuser_q, cm_tuser_d;
    logic [KW-1:0] cm_tkeep_q, cm_tkeep_d;
    logic          cm_tvalid_q, cm_tvalid_d;
    logic          cm_tlast_q, cm_tlast_d;

    logic                      hdr_ours;
    logic                      enc_hit;
    logic [ACT_ADDR_WIDTH-1:0] enc_idx;

    lookup_prio_enc #(
        .N (ENTRIES),
        .W (ACT_ADDR_WIDTH)
    ) u_prio_enc (
        .req (match_q),
        .hit (enc_hit),
        .idx (enc_idx)
    );

    assign hdr_ours = (c_s_axis_tdata[HDR_STAGE_HI:HDR_STAGE_LO] == 4'(STAGE_ID)) &&
                      (c_s_axis_tdata[HDR_MOD_HI:HDR_MOD_LO] == 4'(LKUP_ID));

    // Lookup pipeline; table reads use the pre-commit state, so a same-cycle write is not seen.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match_d[i] = key_valid_in && tbl_valid_q[i] &&
                         (((key_in ^ tbl_key_q[i]) & key_mask_in & tbl_mask_q[i]) == '0);
        end
        phv_s1_d        = phv_in;
        vld_s1_d        = phv_valid_in;
        phv_out_d       = phv_s1_q;
        phv_valid_out_d = vld_s1_q;
        hit_d           = enc_hit;
        addr_d          = enc_idx;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stage_key_d = stage_key_q;
        tbl_key_d   = tbl_key_q;
        tbl_mask_d  = tbl_mask_q;
        tbl_valid_d = tbl_valid_q;
        cm_tdata_d  = c_s_axis_tdata;
        cm_tuser_d  = c_s_axis_tuser;
        cm_tkeep_d  = c_s_axis_tkeep;
        cm_tlast_d  = c_s_axis_tlast;
        cm_tvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (c_s_axis_tvalid) begin
                    if (hdr_ours) begin
                        idx_d = c_s_axis_tdata[HDR_IDX_HI:HDR_IDX_LO];
                        if (!c_s_axis_tlast) state_d = ST_KEY;
                    end else begin
                        cm_tvalid_d = 1'b1;
                        if (!c_s_axis_tlast) state_d = ST_FWD;
                    end
                end
            end
            ST_KEY: begin
                if (c_s_axis_tvalid) begin
                    stage_key_d = c_s_axis_tdata[KEY_LEN-1:0];
                    state_d     = c_s_axis_tlast ? ST_IDLE : ST_MASK;
                end
            end
            ST_MASK: begin
                if (c_s_axis_tvalid) begin
                    // An out-of-range index matches no entry, so the packet is simply consumed.
                    for (int i = 0; i < ENTRIES; i++) begin
                        if (idx_q == 8'(i)) begin
                            tbl_key_d[i]   = stage_key_q;
                            tbl_mask_d[i]  = c_s_axis_tdata[KEY_LEN-1:0];
                            tbl_valid_d[i] = 1'b1;
                        end
                    end
                    state_d = c_s_axis_tlast ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (c_s_axis_tvalid && c_s_axis_tlast) state_d = ST_IDLE;
            end
            ST_FWD: begin
                if (c_s_axis_tvalid) begin
                    cm_tvalid_d = 1'b1;
                    if (c_s_axis_tlast) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            stage_key_q     <= '0;
            tbl_key_q       <= '{default: '0};
            tbl_mask_q      <= '{default: '0};
            tbl_valid_q     <= '0;
            match_q         <= '0;
            phv_s1_q        <= '0;
            vld_s1_q        <= 1'b0;
            phv_out_q       <= '0;
            phv_valid_out_q <= 1'b0;
            addr_q          <= '0;
            hit_q           <= 1'b0;
            cm_tdata_q      <= '0;
            cm_tuser_q      <= '0;
            cm_tkeep_q      <= '0;
            cm_tvalid_q     <= 1'b0;
            cm_tlast_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            stage_key_q     <= stage_key_d;
            tbl_key_q       <= tbl_key_d;
            tbl_mask_q      <= tbl_mask_d;
            tbl_valid_q     <= tbl_valid_d;
            match_q         <= match_d;
            phv_s1_q        <= phv_s1_d;
            vld_s1_q        <= vld_s1_d;
            phv_out_q       <= phv_out_d;
            phv_valid_out_q <= phv_valid_out_d;
            addr_q          <= addr_d;
            hit_q           <= hit_d;
            cm_tdata_q      <= cm_tdata_d;
            cm_tuser_q      <= cm_tuser_d;
            cm_tkeep_q      <= cm_tkeep_d;
            cm_tvalid_q     <= cm_tvalid_d;
            cm_tlast_q      <= cm_tlast_d;
        end
    end

    assign phv_out         = phv_out_q;
    assign phv_valid_out   = phv_valid_out_q;
    assign action_addr_out = addr_q;
    assign hit_out         = hit_q;
    assign c_m_axis_tdata  = cm_tdata_q;
    assign c_m_axis_tuser  = cm_tuser_q;
    assign c_m_axis_tkeep  = cm_tkeep_q;
    assign c_m_axis_tvalid = cm_tvalid_q;
    assign c_m_axis_tlast  = cm_tlast_q;

endmodule
